// File: rtl/wallace_pkg.sv
// Shared definitions for the iterative Wallace multiplier: digit width,
// controller state encoding and the operand magnitude helper.
package wallace_pkg;

    localparam int DIGIT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Magnitude of a 64-bit value that the caller has already sign- or
    // zero-extended from its native width. The most negative native value
    // maps to 2^(WIDTH-1), which still fits the native width unsigned.
    function automatic logic [63:0] abs_w(input logic [63:0] value, input logic sgn);
        return (sgn && value[63]) ? (~value + 64'd1) : value;
    endfunction

endpackage

// File: rtl/mul_digit_row.sv
// Combinational WIDTH x 8 unsigned product built from WIDTH/8 Wallace cells.
// Each cell reduces its eight partial products with carry-save adders
// (8 -> 6 -> 4 -> 3 -> 2 rows) and finishes with one carry-propagate add.
module mul_digit_row #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [7:0]         d_i,
    output logic [WIDTH+7:0]   p_o
);

    localparam int N = WIDTH / 8;

    function automatic void csa(input  logic [15:0] x,
                                input  logic [15:0] y,
                                input  logic [15:0] z,
                                output logic [15:0] s,
                                output logic [15:0] c);
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    function automatic logic [15:0] wallace8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] pp [8];
        logic [15:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;
        for (int i = 0; i < 8; i++)
            pp[i] = b[i] ? (16'(a) << i) : 16'd0;
        csa(pp[0], pp[1], pp[2], s0, c0);
        csa(pp[3], pp[4], pp[5], s1, c1);
        csa(s0, c0, s1, s2, c2);
        csa(c1, pp[6], pp[7], s3, c3);
        csa(s2, c2, s3, s4, c4);
        csa(s4, c4, c3, s5, c5);
        return s5 + c5;
    endfunction

    logic [WIDTH+7:0] sum;

    // Sum the byte-slice products, each weighted by its byte position.
    always_comb begin
        sum = '0;
        for (int k = 0; k < N; k++)
            sum = sum + ((WIDTH + 8)'(wallace8(a_i[8*k +: 8], d_i)) << (8 * k));
    end

    assign p_o = sum;

endmodule

// File: rtl/wallace_mul_iter.sv
// Iterative signed/unsigned multiplier: one 8-bit multiplier digit per
// cycle through a single mul_digit_row, accumulated into a 2*WIDTH register,
// sign applied in a final FIX cycle. Valid/ready on both sides.
// Optional build macro WALLACE_MUL_ZERO_SKIP_EN: finish early once all
// remaining multiplier digits are zero.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | accumulating one multiplier digit per cycle
// FIX   | applying the result sign into the output register
// DONE  | product valid, held until the sink accepts it
module wallace_mul_iter
    import wallace_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sgn,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);

    localparam int N     = WIDTH / DIGIT_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW    = 2 * WIDTH;

    state_t                   state_q, state_d;
    logic [PW-1:0]            acc_q, acc_d;
    logic [PW-1:0]            p_q, p_d;
    logic [WIDTH-1:0]         a_mag_q, a_mag_d;
    logic [WIDTH-1:0]         b_mag_q, b_mag_d;
    logic                     neg_q, neg_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [DIGIT_W-1:0]       digit;
    logic [WIDTH+DIGIT_W-1:0] row_p;
    logic                     last_digit;

    assign digit = DIGIT_W'(b_mag_q >> (DIGIT_W * 32'(idx_q)));

    mul_digit_row #(.WIDTH(WIDTH)) u_row (
        .a_i (a_mag_q),
        .d_i (digit),
        .p_o (row_p)
    );

`ifdef WALLACE_MUL_ZERO_SKIP_EN
    assign last_digit = (idx_q == IDX_W'(N - 1)) ||
                        ((b_mag_q >> (DIGIT_W * (32'(idx_q) + 32'd1))) == '0);
`else
    assign last_digit = (idx_q == IDX_W'(N - 1));
`endif

    // Next-state and datapath update; handshake outputs decoded from state.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        p_d       = p_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        neg_d     = neg_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_mag_d = WIDTH'(abs_w(in_sgn ? 64'($signed(in_a)) : 64'(in_a), in_sgn));
                    b_mag_d = WIDTH'(abs_w(in_sgn ? 64'($signed(in_b)) : 64'(in_b), in_sgn));
                    neg_d   = in_sgn & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_q + (PW'(row_p) << (DIGIT_W * 32'(idx_q)));
                idx_d = idx_q + IDX_W'(1);
                if (last_digit)
                    state_d = FIX;
            end
            FIX: begin
                p_d     = neg_q ? (~acc_q + PW'(1)) : acc_q;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            p_q     <= '0;
            a_mag_q <= '0;
            b_mag_q <= '0;
            neg_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            neg_q   <= neg_d;
            idx_q   <= idx_d;
        end
    end

    assign out_p = p_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: doc/wallace_mul_iter.md
# wallace_mul_iter

Parametrised, iterative signed/unsigned multiplier: the sequential successor to the combinational 32x32 Wallace multiplier. It multiplies a WIDTH-bit multiplicand by one 8-bit digit of the multiplier per cycle, using a row of 8x8 Wallace cells, and accumulates the results into a 2*WIDTH-bit register. Operands and product move over valid/ready handshakes, so the block sits between a request source and a result sink in the datapath. Per-transaction signed mode replaces the fixed-signedness combinational path.

## Interface
- WIDTH, 32, operand width; multiple of 8, range 8..64
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand request valid
- in_ready  out  1  block can accept operands
- in_sgn  in  1  1: operands are two's complement; 0: unsigned
- in_a  in  WIDTH  multiplicand
- in_b  in  WIDTH  multiplier
- out_valid  out  1  product valid
- out_ready  in  1  sink accepts product
- out_p  out  2*WIDTH  product, two's complement if the transaction was signed
- busy  out  1  high in every state except IDLE

## Operation
- N = WIDTH/8 digits. State machine: IDLE, BUSY, FIX, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture |in_a| and |in_b| as WIDTH-bit unsigned magnitudes. In unsigned mode the magnitude is the raw value. neg = in_sgn & (a_msb ^ b_msb). Clear acc and idx, then go to BUSY.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits in WIDTH unsigned bits. No overflow is possible in any mode.
- BUSY: acc += row(a_mag, b_mag[8*idx +: 8]) << 8*idx, then idx++. After idx==N-1 is processed, go to FIX.
- FIX: out_p <= neg ? -acc : acc (2*WIDTH-bit two's complement). Go to DONE.
- DONE: out_valid=1. out_p and out_valid hold stable until out_ready. On out_valid&&out_ready, go to IDLE.
- in_ready = (state==IDLE) only. A new operand is never accepted in DONE, even when out_ready is high.
- Inputs are ignored outside the accepting cycle.
- Reset (any time, including mid-transaction): state=IDLE, acc=0, idx=0, out_p=0, out_valid=0, busy=0, in_ready=1. A partial transaction is discarded with no output.

## Timing
- Accepting edge E0. BUSY runs on edges E1..EN. FIX completes on E(N+1). out_valid is high after edge E(N+1).
- For WIDTH=32, out_valid is high 5 edges after accept.
- Minimum accept-to-accept period: N+3 cycles, assuming out_ready is held high.
- out_p is registered. There is no combinational path from inputs to outputs except in_ready/out_valid, which come from state.
- in_sgn is sampled only at accept.

## Configuration
- WALLACE_MUL_ZERO_SKIP_EN defined: in BUSY, after processing digit idx, if b_mag digits idx+1..N-1 are all zero, go directly to FIX.
  - Latency becomes (index of highest nonzero digit of b_mag, min 0) + 2 edges.
  - b=0 yields 0 after 2 edges.
- Not defined: latency is always N+1 edges and there is no zero detect logic.
- Product value is identical in both builds.

## Structure
- Shared package wallace_pkg:
  - DIGIT_W=8 constant
  - state enum type (IDLE, BUSY, FIX, DONE)
  - magnitude function abs_w(value, sgn)
- Sub-module mul_digit_row:
  - purely combinational WIDTH x 8 unsigned product (WIDTH+8 bits)
  - built from WIDTH/8 8x8 Wallace cells whose partial products are shifted by 8 and summed
  - one instance only

## Test plan
- WIDTH=32, unsigned, a=b=0xFFFFFFFF → out_p=0xFFFFFFFE00000001, out_valid 5 edges after accept.
- WIDTH=32, signed, a=b=0x80000000 → out_p=0x4000000000000000. Signed a=-3 (0xFFFFFFFD), b=5 → 0xFFFFFFFFFFFFFFF1. Same bits unsigned, a=0xFFFFFFFD, b=5 → 0x00000004FFFFFFF1.
- Back-pressure: out_ready low 3 cycles after out_valid → out_p stable, in_ready=0, busy=1. Release → IDLE next edge, in_ready=1.
- Assert rst for 1 cycle at edge E2 of a transaction → out_valid never rises, in_ready=1 immediately. Next transaction 7*9 → 63 with normal latency.
- Zero-skip, unsigned a=0x12345678, b=5 → out_p=0x000000005B05B058. out_valid after 2 edges with WALLACE_MUL_ZERO_SKIP_EN defined, after 5 edges without.
- WIDTH=8 and WIDTH=64, 1000 random signed/unsigned pairs with random out_ready stalls → all products match the reference model, and no transaction is lost or duplicated.
